// File: rtl/raster_bbox_scanner_pkg.sv
// Shared definitions for the raster front end: coordinate formats, scanner
// FSM encodings and the pixel-centre helper. The weight stage imports the
// same package so both sides agree on the Q10.6 layout.
package raster_bbox_scanner_pkg;

   // Coordinate format: signed Q10.6 held in 16 bits.
   localparam int RB_FRAC_BITS = 6;
   localparam int COORD_W      = 16;

   // Integer pixel counters. A signed 11-bit value covers the full floor
   // range of a Q10.6 coordinate (-512..511) with room to spare.
   localparam int PIX_W        = 11;

   // Default screen size.
   localparam int RB_SCREEN_W  = 320;
   localparam int RB_SCREEN_H  = 240;

   // Pixel-centre offset for the default fraction width (half a pixel).
   localparam logic signed [COORD_W-1:0] RB_CENTRE_OFF = COORD_W'(1 << (RB_FRAC_BITS - 1));

   // Scanner FSM encodings.
   //   IDLE  : waiting for a triangle, tri_ready high
   //   SETUP : latched vertices -> registered clamped bounding box
   //   ARM   : bounding box known; either reject as empty or load counters
   //   SCAN  : emitting pixels in raster order
   //   DONE  : tri_done pulse cycle, still not ready for a new triangle
   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_SETUP = 3'd1;
   localparam logic [2:0] ST_ARM   = 3'd2;
   localparam logic [2:0] ST_SCAN  = 3'd3;
   localparam logic [2:0] ST_DONE  = 3'd4;

   // Integer pixel index -> Q10.6 pixel centre, using shift and offset only.
   function automatic logic signed [COORD_W-1:0] pix_centre(
      input logic signed [PIX_W-1:0] c,
      input int                      frac
   );
      logic signed [COORD_W-1:0] w;
      w = {{(COORD_W - PIX_W){c[PIX_W-1]}}, c};
      return (w <<< frac) + COORD_W'(1 << (frac - 1));
   endfunction

endpackage

// File: rtl/raster_bbox_scanner_bbox_min_max3.sv
// Combinational bounding-box extent along one axis: min and max of three
// signed Q10.6 coordinates, floored to integer pixels and clamped to the
// screen. Each bound is clamped only toward the screen interior, so a
// triangle fully off one side produces lo > hi and is seen as empty.
module bbox_min_max3
   import raster_bbox_scanner_pkg::*;
#(
   parameter int FRAC_BITS = RB_FRAC_BITS,
   parameter int LIMIT     = RB_SCREEN_W - 1
) (
   input  logic signed [COORD_W-1:0] a,
   input  logic signed [COORD_W-1:0] b,
   input  logic signed [COORD_W-1:0] c,
   output logic signed [PIX_W-1:0]   lo,
   output logic signed [PIX_W-1:0]   hi
);

   localparam logic signed [PIX_W-1:0] LIM = PIX_W'(LIMIT);

   logic signed [COORD_W-1:0] mn;
   logic signed [COORD_W-1:0] mx;
   logic signed [PIX_W-1:0]   mn_i;
   logic signed [PIX_W-1:0]   mx_i;

   // Floor is monotonic, so min/max are taken on the raw coordinates first.
   always_comb begin
      mn = a;
      if (b < mn) mn = b;
      if (c < mn) mn = c;
      mx = a;
      if (b > mx) mx = b;
      if (c > mx) mx = c;
   end

   // Floor by arithmetic shift, then clamp lower bound up and upper bound down.
   always_comb begin
      mn_i = PIX_W'(mn >>> FRAC_BITS);
      mx_i = PIX_W'(mx >>> FRAC_BITS);
      lo   = mn_i[PIX_W-1] ? '0 : mn_i;
      hi   = (mx_i > LIM) ? LIM : mx_i;
   end

endmodule

// File: rtl/raster_bbox_scanner.sv
// Triangle bounding-box raster scanner. Accepts one triangle, registers its
// screen-clamped integer bounding box and walks every pixel in raster order,
// emitting pixel centres together with the latched vertices.
//
// Handshakes (both ports): a transfer happens on a rising edge where valid
// and ready are both high. A producer holding valid keeps its payload stable
// until the transfer; tri_ready and pix_valid never depend combinationally
// on tri_valid or pix_ready.
module raster_bbox_scanner
   import raster_bbox_scanner_pkg::*;
#(
   parameter int FRAC_BITS = RB_FRAC_BITS,
   parameter int SCREEN_W  = RB_SCREEN_W,
   parameter int SCREEN_H  = RB_SCREEN_H
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      tri_valid,
   output logic                      tri_ready,
   input  logic signed [COORD_W-1:0] v0x,
   input  logic signed [COORD_W-1:0] v0y,
   input  logic signed [COORD_W-1:0] v1x,
   input  logic signed [COORD_W-1:0] v1y,
   input  logic signed [COORD_W-1:0] v2x,
   input  logic signed [COORD_W-1:0] v2y,
   output logic                      pix_valid,
   input  logic                      pix_ready,
   output logic signed [COORD_W-1:0] px,
   output logic signed [COORD_W-1:0] py,
   output logic                      pix_last,
   output logic signed [COORD_W-1:0] o_v0x,
   output logic signed [COORD_W-1:0] o_v0y,
   output logic signed [COORD_W-1:0] o_v1x,
   output logic signed [COORD_W-1:0] o_v1y,
   output logic signed [COORD_W-1:0] o_v2x,
   output logic signed [COORD_W-1:0] o_v2y,
   output logic                      tri_done,
   output logic [2:0]                dbg_state
);

   logic [2:0]              state;

   // Registered bounding box and scan counters.
   logic signed [PIX_W-1:0] xmin;
   logic signed [PIX_W-1:0] xmax;
   logic signed [PIX_W-1:0] ymin;
   logic signed [PIX_W-1:0] ymax;
   logic signed [PIX_W-1:0] cx;
   logic signed [PIX_W-1:0] cy;
   logic                    empty_q;

   // Combinational bounding box from the latched vertices.
   logic signed [PIX_W-1:0] bx_lo;
   logic signed [PIX_W-1:0] bx_hi;
   logic signed [PIX_W-1:0] by_lo;
   logic signed [PIX_W-1:0] by_hi;

   logic                    pix_hs;
   logic                    at_row_end;
   logic                    at_last;

   bbox_min_max3 #(
      .FRAC_BITS (FRAC_BITS),
      .LIMIT     (SCREEN_W - 1)
   ) u_bbox_x (
      .a  (o_v0x),
      .b  (o_v1x),
      .c  (o_v2x),
      .lo (bx_lo),
      .hi (bx_hi)
   );

   bbox_min_max3 #(
      .FRAC_BITS (FRAC_BITS),
      .LIMIT     (SCREEN_H - 1)
   ) u_bbox_y (
      .a  (o_v0y),
      .b  (o_v1y),
      .c  (o_v2y),
      .lo (by_lo),
      .hi (by_hi)
   );

   // Status and pixel outputs decoded from state and counters.
   always_comb begin
      tri_ready  = (state == ST_IDLE);
      pix_valid  = (state == ST_SCAN);
      pix_hs     = pix_valid & pix_ready;
      at_row_end = (cx == xmax);
      at_last    = at_row_end && (cy == ymax);
      pix_last   = pix_valid & at_last;
      // Outside a scan the centre outputs read zero, matching reset.
      px         = pix_valid ? pix_centre(cx, FRAC_BITS) : '0;
      py         = pix_valid ? pix_centre(cy, FRAC_BITS) : '0;
      dbg_state  = state;
   end

   // Scanner FSM, vertex latch, bounding-box registers and raster counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         o_v0x    <= '0;
         o_v0y    <= '0;
         o_v1x    <= '0;
         o_v1y    <= '0;
         o_v2x    <= '0;
         o_v2y    <= '0;
         xmin     <= '0;
         xmax     <= '0;
         ymin     <= '0;
         ymax     <= '0;
         cx       <= '0;
         cy       <= '0;
         empty_q  <= 1'b0;
         tri_done <= 1'b0;
      end else begin
         tri_done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (tri_valid) begin
                  o_v0x <= v0x;
                  o_v0y <= v0y;
                  o_v1x <= v1x;
                  o_v1y <= v1y;
                  o_v2x <= v2x;
                  o_v2y <= v2y;
                  state <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               xmin    <= bx_lo;
               xmax    <= bx_hi;
               ymin    <= by_lo;
               ymax    <= by_hi;
               empty_q <= (bx_lo > bx_hi) || (by_lo > by_hi);
               state   <= ST_ARM;
            end
            ST_ARM: begin
               if (empty_q) begin
                  tri_done <= 1'b1;
                  state    <= ST_DONE;
               end else begin
                  cx    <= xmin;
                  cy    <= ymin;
                  state <= ST_SCAN;
               end
            end
            ST_SCAN: begin
               if (pix_hs) begin
                  if (at_last) begin
                     tri_done <= 1'b1;
                     state    <= ST_DONE;
                  end else if (at_row_end) begin
                     cx <= xmin;
                     cy <= cy + PIX_W'(1);
                  end else begin
                     cx <= cx + PIX_W'(1);
                  end
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_raster_bbox_scanner.sv
// Self-checking bench for raster_bbox_scanner: table of directed triangles,
// a mid-scan reset sequence and randomized triangles, all compared against a
// pixel-list reference model built from the bounding-box rules.
module tb_raster_bbox_scanner;

   localparam int SW = 320;
   localparam int SH = 240;

   logic               clk;
   logic               rst;
   logic               tri_valid;
   logic               tri_ready;
   logic signed [15:0] v0x, v0y, v1x, v1y, v2x, v2y;
   logic               pix_valid;
   logic               pix_ready;
   logic signed [15:0] px, py;
   logic               pix_last;
   logic signed [15:0] o_v0x, o_v0y, o_v1x, o_v1y, o_v2x, o_v2y;
   logic               tri_done;
   logic [2:0]         dbg_state;

   int n_checks = 0;
   int n_fail   = 0;

   // Scoreboard: expected {px, py} in emission order.
   logic [31:0] exp_q[$];

   typedef struct {
      int ax, ay, bx, by, cx, cy;
      int stall_at;
      int exp_n;
      int first_px, first_py, last_px, last_py;
   } vec_t;

   vec_t vecs[5];

   raster_bbox_scanner dut (
      .clk       (clk),
      .rst       (rst),
      .tri_valid (tri_valid),
      .tri_ready (tri_ready),
      .v0x       (v0x),
      .v0y       (v0y),
      .v1x       (v1x),
      .v1y       (v1y),
      .v2x       (v2x),
      .v2y       (v2y),
      .pix_valid (pix_valid),
      .pix_ready (pix_ready),
      .px        (px),
      .py        (py),
      .pix_last  (pix_last),
      .o_v0x     (o_v0x),
      .o_v0y     (o_v0y),
      .o_v1x     (o_v1x),
      .o_v1y     (o_v1y),
      .o_v2x     (o_v2x),
      .o_v2y     (o_v2y),
      .tri_done  (tri_done),
      .dbg_state (dbg_state)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Floor division by 64 with mathematical rounding toward minus infinity.
   function automatic int floor64(input int v);
      if (v >= 0) return v / 64;
      return -((-v + 63) / 64);
   endfunction

   function automatic int min3(input int a, input int b, input int c);
      int m;
      m = a;
      if (b < m) m = b;
      if (c < m) m = c;
      return m;
   endfunction

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return m;
   endfunction

   // Reference model: list every pixel centre of the clamped bounding box.
   task automatic model_fill(input int ax, input int ay, input int bx, input int by, input int cx, input int cy);
      int x0, x1, y0, y1;
      exp_q.delete();
      x0 = floor64(min3(ax, bx, cx));
      x1 = floor64(max3(ax, bx, cx));
      y0 = floor64(min3(ay, by, cy));
      y1 = floor64(max3(ay, by, cy));
      if (x0 < 0) x0 = 0;
      if (y0 < 0) y0 = 0;
      if (x1 > SW - 1) x1 = SW - 1;
      if (y1 > SH - 1) y1 = SH - 1;
      for (int y = y0; y <= y1; y++)
         for (int x = x0; x <= x1; x++)
            exp_q.push_back({16'(x * 64 + 32), 16'(y * 64 + 32)});
   endtask

   // Drive one triangle and follow it to tri_done, checking every pixel.
   task automatic run_tri(input int ax, input int ay, input int bx, input int by, input int cx, input int cy,
                          input int rdy_pct, input int stall_at,
                          output int n_hs, output int f_px, output int f_py, output int l_px, output int l_py);
      int  waited;
      int  first_evt;
      int  stall_cnt;
      bit  done;
      bit  pr;
      bit  held;
      logic signed [15:0] h_px, h_py;
      logic h_last;
      logic [31:0] e;

      n_hs = 0; f_px = -1; f_py = -1; l_px = -1; l_py = -1;
      first_evt = -1; stall_cnt = 0; done = 0; held = 0;
      h_px = '0; h_py = '0; h_last = 1'b0;
      model_fill(ax, ay, bx, by, cx, cy);

      waited = 0;
      @(negedge clk);
      while (!tri_ready && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      if (!tri_ready) begin
         check("tri_ready wait timeout", 0, 1);
         return;
      end
      tri_valid = 1'b1;
      v0x = 16'(ax); v0y = 16'(ay);
      v1x = 16'(bx); v1y = 16'(by);
      v2x = 16'(cx); v2y = 16'(cy);
      @(negedge clk);
      tri_valid = 1'b0;
      // Vertex inputs are free to change once the triangle is taken.
      v0x = 16'($urandom); v0y = 16'($urandom);
      v1x = 16'($urandom); v1y = 16'($urandom);
      v2x = 16'($urandom); v2y = 16'($urandom);
      check("tri_ready low after accept", 32'(tri_ready), 0);

      for (int idx = 0; idx < 3000; idx++) begin
         if (pix_valid && n_hs == stall_at && stall_cnt < 3) begin
            pr = 1'b0;
            stall_cnt++;
         end else begin
            pr = ($urandom_range(0, 99) < rdy_pct);
         end
         pix_ready = pr;

         if (held) begin
            check("hold pix_valid", 32'(pix_valid), 1);
            check("hold px", px, h_px);
            check("hold py", py, h_py);
            check("hold pix_last", 32'(pix_last), 32'(h_last));
            held = 0;
         end

         if (tri_done) begin
            check("pix_valid low at tri_done", 32'(pix_valid), 0);
            check("tri_ready low at tri_done", 32'(tri_ready), 0);
            if (n_hs == 0) check("empty tri_done latency", idx, 2);
            done = 1;
            break;
         end

         if (pix_valid) begin
            if (first_evt < 0) begin
               first_evt = idx;
               check("first pix_valid latency", idx, 2);
            end
            if (pr) begin
               if (exp_q.size() == 0) begin
                  check("extra pixel", n_hs, -1);
               end else begin
                  check("pix_last", 32'(pix_last), 32'(exp_q.size() == 1));
                  e = exp_q.pop_front();
                  check("px", px, $signed({16'h0, e[31:16]}));
                  check("py", py, $signed({16'h0, e[15:0]}));
                  check("o_v0x", o_v0x, ax);
                  check("o_v2y", o_v2y, cy);
               end
               if (n_hs == 0) begin f_px = px; f_py = py; end
               l_px = px; l_py = py;
               n_hs++;
            end else begin
               held = 1; h_px = px; h_py = py; h_last = pix_last;
            end
         end
         @(negedge clk);
      end

      if (!done) begin
         check("tri_done timeout", 0, 1);
         return;
      end
      check("no missing pixels", exp_q.size(), 0);
      @(negedge clk);
      pix_ready = 1'b0;
      check("tri_done one cycle", 32'(tri_done), 0);
      check("tri_ready after tri_done", 32'(tri_ready), 1);
   endtask

   initial begin
      int n, fx, fy, lx, ly, hs, waited;
      int ax, ay, bx, by, cx, cy, bx0, by0;

      vecs[0] = '{ax:0, ay:0, bx:128, by:0, cx:0, cy:64, stall_at:-1, exp_n:6,
                  first_px:32, first_py:32, last_px:160, last_py:96};
      vecs[1] = '{ax:0, ay:0, bx:128, by:0, cx:0, cy:64, stall_at:2, exp_n:6,
                  first_px:32, first_py:32, last_px:160, last_py:96};
      vecs[2] = '{ax:-320, ay:-192, bx:64, by:64, cx:25600, cy:64, stall_at:-1, exp_n:640,
                  first_px:32, first_py:32, last_px:20448, last_py:96};
      vecs[3] = '{ax:-640, ay:0, bx:-128, by:0, cx:-320, cy:64, stall_at:-1, exp_n:0,
                  first_px:-1, first_py:-1, last_px:-1, last_py:-1};
      vecs[4] = '{ax:330, ay:450, bx:340, by:460, cx:350, cy:455, stall_at:-1, exp_n:1,
                  first_px:352, first_py:480, last_px:352, last_py:480};

      // Reset
      rst = 1'b1; tri_valid = 1'b0; pix_ready = 1'b0;
      v0x = '0; v0y = '0; v1x = '0; v1y = '0; v2x = '0; v2y = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("reset tri_ready", 32'(tri_ready), 1);
      check("reset pix_valid", 32'(pix_valid), 0);
      check("reset tri_done", 32'(tri_done), 0);
      check("reset pix_last", 32'(pix_last), 0);
      check("reset px", px, 0);
      check("reset py", py, 0);
      check("reset o_v0x", o_v0x, 0);
      check("reset o_v2y", o_v2y, 0);

      // Directed table
      for (int i = 0; i < 5; i++) begin
         run_tri(vecs[i].ax, vecs[i].ay, vecs[i].bx, vecs[i].by, vecs[i].cx, vecs[i].cy,
                 100, vecs[i].stall_at, n, fx, fy, lx, ly);
         check($sformatf("vec%0d count", i), n, vecs[i].exp_n);
         if (vecs[i].exp_n > 0) begin
            check($sformatf("vec%0d first px", i), fx, vecs[i].first_px);
            check($sformatf("vec%0d first py", i), fy, vecs[i].first_py);
            check($sformatf("vec%0d last px", i), lx, vecs[i].last_px);
            check($sformatf("vec%0d last py", i), ly, vecs[i].last_py);
         end
      end

      // Reset after the second handshake drops the triangle at once.
      @(negedge clk);
      tri_valid = 1'b1;
      v0x = 16'sd0; v0y = 16'sd0; v1x = 16'sd128; v1y = 16'sd0; v2x = 16'sd0; v2y = 16'sd64;
      @(negedge clk);
      tri_valid = 1'b0;
      pix_ready = 1'b1;
      hs = 0; waited = 0;
      while (hs < 2 && waited < 20) begin
         if (pix_valid) hs++;
         @(negedge clk);
         waited++;
      end
      check("reset seq handshakes", hs, 2);
      rst = 1'b1; pix_ready = 1'b0;
      @(negedge clk);
      check("mid-scan reset pix_valid", 32'(pix_valid), 0);
      check("mid-scan reset tri_done", 32'(tri_done), 0);
      rst = 1'b0;
      @(negedge clk);
      check("after reset tri_ready", 32'(tri_ready), 1);
      check("after reset tri_done", 32'(tri_done), 0);
      run_tri(0, 0, 128, 0, 0, 64, 100, -1, n, fx, fy, lx, ly);
      check("rescan count", n, 6);
      check("rescan first px", fx, 32);
      check("rescan first py", fy, 32);

      // Randomized triangles with random backpressure
      for (int t = 0; t < 12; t++) begin
         bx0 = int'($urandom_range(0, 360 * 64)) - 20 * 64;
         by0 = int'($urandom_range(0, 280 * 64)) - 20 * 64;
         ax = bx0 + int'($urandom_range(0, 12 * 64));
         bx = bx0 + int'($urandom_range(0, 12 * 64));
         cx = bx0 + int'($urandom_range(0, 12 * 64));
         ay = by0 + int'($urandom_range(0, 12 * 64));
         by = by0 + int'($urandom_range(0, 12 * 64));
         cy = by0 + int'($urandom_range(0, 12 * 64));
         run_tri(ax, ay, bx, by, cx, cy, 70, -1, n, fx, fy, lx, ly);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
